// File: rtl/sr_d_deserializer_pkg.sv
// Shared constants and FSM state type for the SR-D deserialiser slice.
// The optional parity phase is controlled by SR_D_DESER_PARITY_EN.
package sr_d_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned MIN_WIDTH     = 2;
    localparam int unsigned MAX_WIDTH     = 32;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } deser_state_e;

    // Even parity across a data word plus its trailing parity bit; 1 means error.
    function automatic logic even_parity_err(input logic [MAX_WIDTH-1:0] word,
                                             input logic                 par_bit);
        return (^word) ^ par_bit;
    endfunction

endpackage

// File: rtl/sr_d_deserializer_if.sv
// Serial input, parallel valid/ready output and status bundle of the deserialiser.
interface sr_d_deserializer_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             bit_in;
    logic             bit_en;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             ovf_clr;
    logic             overflow;
    logic             parity_err;

    // Environment side: drives serial bits, consumer ready and overflow clear.
    modport master (
        output bit_in,
        output bit_en,
        output out_ready,
        output ovf_clr,
        input  out_data,
        input  out_valid,
        input  overflow,
        input  parity_err
    );

    // Deserialiser side.
    modport slave (
        input  bit_in,
        input  bit_en,
        input  out_ready,
        input  ovf_clr,
        output out_data,
        output out_valid,
        output overflow,
        output parity_err
    );

endinterface

// File: rtl/sr_d_deserializer_bit_counter.sv
// Data-bit counter for the deserialiser: counts enabled edges and wraps to 0
// after the terminal count WIDTH-1.
module sr_d_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sr_d_deserializer.sv
// MSB-first serial-to-parallel packer with valid/ready output and sticky overflow.
// Optional trailing even-parity bit enabled by defining SR_D_DESER_PARITY_EN.
module sr_d_deserializer
    import sr_d_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    sr_d_deserializer_if.slave   bus
);

`ifdef SR_D_DESER_PARITY_EN
    localparam int unsigned SH_W = WIDTH;
`else
    localparam int unsigned SH_W = WIDTH - 1;
`endif

    deser_state_e     state_q, state_d;
    logic [SH_W-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             tc_c;
    logic             cnt_en_c;
    logic             word_done_c;
    logic [WIDTH-1:0] word_c;
    logic [WIDTH-1:0] shift_c;

    // Counter only advances on data bits, never on the parity bit.
    assign cnt_en_c = bus.bit_en && (state_q == COLLECT);

    sr_d_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en_c),
        .tc_c  (tc_c)
    );

    assign shift_c = {shreg_q[WIDTH-2:0], bus.bit_in};

`ifdef SR_D_DESER_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic par_bit_c;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        word_done_c = 1'b0;
        word_c      = shift_c;
`ifdef SR_D_DESER_PARITY_EN
        parity_err_d = parity_err_q;
        par_bit_c    = 1'b0;
`endif

        unique case (state_q)
            COLLECT: begin
                if (bus.bit_en) begin
                    shreg_d = SH_W'(shift_c);
                    if (tc_c) begin
`ifdef SR_D_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        word_done_c = 1'b1;
`endif
                    end
                end
            end
`ifdef SR_D_DESER_PARITY_EN
            PARITY: begin
                word_c    = WIDTH'(shreg_q);
                par_bit_c = bus.bit_in;
                if (bus.bit_en) begin
                    word_done_c = 1'b1;
                    state_d     = COLLECT;
                end
            end
`endif
            default: state_d = COLLECT;
        endcase

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (ovf_clr_c()) begin
            overflow_d = 1'b0;
        end

        // A completed word lands only if the output slot is free or being taken.
        if (word_done_c) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = word_c;
                out_valid_d = 1'b1;
`ifdef SR_D_DESER_PARITY_EN
                parity_err_d = even_parity_err(MAX_WIDTH'(word_c), par_bit_c);
`endif
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    function automatic logic ovf_clr_c();
        return bus.ovf_clr;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= COLLECT;
            shreg_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef SR_D_DESER_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_sr_d_deserializer.sv
// Directed and randomized bench for sr_d_deserializer against a word-level model.
// Follows SR_D_DESER_PARITY_EN to decide whether a parity bit trails each word.
module tb_sr_d_deserializer;

    localparam int unsigned W = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sr_d_deserializer_if #(.WIDTH(W)) bus ();

    sr_d_deserializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits gathered into an integer word, then offered to a one-slot buffer.
    int unsigned m_acc;
    int          m_nbits;
    bit          m_await_par;
    bit [W-1:0]  m_data;
    bit          m_valid;
    bit          m_ovf;
    bit          m_perr;

`ifdef SR_D_DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_nbits = 0; m_await_par = 0;
        m_data = '0; m_valid = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic model_edge(input bit en, input bit b, input bit rdy, input bit clr);
        bit          done;
        bit [W-1:0]  word;
        bit          par;
        int          ones;
        done = 0; word = '0; par = 0;
        if (en) begin
            if (m_await_par) begin
                done = 1; par = b; word = W'(m_acc); m_await_par = 0; m_acc = 0;
            end else begin
                m_acc   = (m_acc * 2 + int'(b)) % (1 << W);
                m_nbits = m_nbits + 1;
                if (m_nbits == W) begin
                    m_nbits = 0;
                    if (PAR_EN) m_await_par = 1;
                    else begin done = 1; word = W'(m_acc); m_acc = 0; end
                end
            end
        end
        if (clr) m_ovf = 0;
        if (done) begin
            if (!m_valid || rdy) begin
                m_data = word;
                m_valid = 1;
                ones = int'(par);
                for (int i = 0; i < int'(W); i++) ones += int'(word[i]);
                if (PAR_EN) m_perr = (ones % 2) != 0;
            end else begin
                m_ovf = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".data"},  32'(bus.out_data),   32'(m_data));
        chk({tag, ".valid"}, 32'(bus.out_valid),  32'(m_valid));
        chk({tag, ".ovf"},   32'(bus.overflow),   32'(m_ovf));
        chk({tag, ".perr"},  32'(bus.parity_err), 32'(m_perr));
    endtask

    task automatic step(input bit rst_n, input bit en, input bit b, input bit rdy, input bit clr);
        reset         = rst_n;
        bus.bit_en    = en;
        bus.bit_in    = b;
        bus.out_ready = rdy;
        bus.ovf_clr   = clr;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(en, b, rdy, clr);
        #1;
        check_outputs("step");
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit par, input bit gaps, input bit rdy);
        logic [W-1:0] v;
        v = w;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (gaps) step(1, 0, 1'b1, rdy, 0);
            step(1, 1, v[i], rdy, 0);
        end
        if (PAR_EN) begin
            if (gaps) step(1, 0, 1'b0, rdy, 0);
            step(1, 1, par, rdy, 0);
        end
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_reset();
        reset = 1'b0;
        bus.bit_in = 0; bus.bit_en = 0; bus.out_ready = 0; bus.ovf_clr = 0;

        do_reset();
        chk("rst_data",  32'(bus.out_data),  32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_ovf",   32'(bus.overflow),  32'h0);

        // Plain word with a ready consumer.
        send_word(8'hB2, 1'b0, 1'b0, 1'b1);
        chk("b2_data",  32'(bus.out_data),  32'hB2);
        chk("b2_valid", 32'(bus.out_valid), 32'h1);
        chk("b2_ovf",   32'(bus.overflow),  32'h0);
        step(1, 0, 0, 1, 0);
        chk("b2_taken", 32'(bus.out_valid), 32'h0);

        // Same word with idle cycles between qualified bits.
        send_word(8'hB2, 1'b0, 1'b1, 1'b1);
        chk("gap_data",  32'(bus.out_data),  32'hB2);
        chk("gap_valid", 32'(bus.out_valid), 32'h1);
        step(1, 0, 0, 1, 0);

        // Stalled consumer: second word dropped, overflow sticky until cleared.
        send_word(8'hB2, 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("ovf_data", 32'(bus.out_data), 32'hB2);
        chk("ovf_set",  32'(bus.overflow), 32'h1);
        step(1, 0, 0, 0, 1);
        chk("ovf_clr",  32'(bus.overflow), 32'h0);
        chk("ovf_hold", 32'(bus.out_valid), 32'h1);
        step(1, 0, 0, 1, 0);
        chk("ovf_take", 32'(bus.out_valid), 32'h0);

        // Back-to-back stream at full throughput.
        send_word(8'h01, 1'b1, 1'b0, 1'b1);
        chk("s1", 32'(bus.out_data), 32'h01);
        send_word(8'h02, 1'b1, 1'b0, 1'b1);
        chk("s2", 32'(bus.out_data), 32'h02);
        chk("s2_valid", 32'(bus.out_valid), 32'h1);
        send_word(8'h03, 1'b0, 1'b0, 1'b1);
        chk("s3", 32'(bus.out_data), 32'h03);
        chk("s_ovf", 32'(bus.overflow), 32'h0);
        step(1, 0, 0, 1, 0);

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
        do_reset();
        send_word(8'h0F, 1'b0, 1'b0, 1'b1);
        chk("rmid_data", 32'(bus.out_data), 32'h0F);

`ifdef SR_D_DESER_PARITY_EN
        send_word(8'hB2, 1'b0, 1'b0, 1'b1);
        chk("par_ok",  32'(bus.parity_err), 32'h0);
        send_word(8'hB2, 1'b1, 1'b0, 1'b1);
        chk("par_bad", 32'(bus.parity_err), 32'h1);
`endif

        // Randomized traffic including clears, stalls and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_d_deserializer.md
# sr_d_deserializer

Serial-in, parallel-out deserialiser that consumes the bit stream produced by the SR-based D flip-flop stage (its `q` output) and packs it into WIDTH-bit words. Bits are accepted on qualified clock edges, assembled MSB-first, and presented on a valid/ready output port with sticky overflow detection. It sits directly downstream of the D-conversion stage and feeds word-level logic.

## Interface
- WIDTH, 8, data bits per word; legal range 2..32
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  synchronous, active-low; sampled on posedge clk
- bit_in  input  1  serial data bit (the upstream D stage `q`)
- bit_en  input  1  bit_in is captured on this edge when high
- out_data  output  WIDTH  assembled word; first received bit in MSB
- out_valid  output  1  out_data holds an untaken word
- out_ready  input  1  consumer accepts word when out_valid && out_ready
- ovf_clr  input  1  clears overflow
- overflow  output  1  sticky: a completed word was dropped
- parity_err  output  1  parity of presented word failed (tied 0 when feature compiled out)

## Operation
- Reset values: out_data=0, out_valid=0, overflow=0, parity_err=0, shift register=0, bit count=0, state=COLLECT.
- FSM states: COLLECT (data bits), PARITY (only with SR_D_DESER_PARITY_EN).
- COLLECT, bit_en=1: shreg <= {shreg[WIDTH-2:0], bit_in}; cnt++. bit_en=0: hold everything except output handshake.
- Word completes on the edge capturing bit WIDTH-1 (cnt == WIDTH-1) without parity; on the parity bit with parity. cnt returns to 0, state returns to COLLECT.
- On completion: if out_valid=0, or out_valid && out_ready on the same edge, out_data <= new word, out_valid stays/goes 1. Otherwise word dropped, out_data unchanged, overflow <= 1.
- Handshake: out_valid && out_ready with no completion on that edge -> out_valid <= 0. out_data is held stable while out_valid=1 and not taken.
- overflow: set as above; cleared by ovf_clr=1; set wins over clear on the same edge.
- Reset mid-word: partial word discarded, pending output word discarded.
- cnt width $clog2(WIDTH); no wrap beyond WIDTH-1.

## Timing
- Word appears on out_data/out_valid the cycle after the edge capturing its final bit (1-cycle latency from last bit_en).
- Back-to-back words with continuous bit_en: full throughput if consumer holds out_ready=1; new word replaces taken word on the same edge, out_valid stays high.
- Minimum time between completions: WIDTH cycles (WIDTH+1 with parity).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- Macro: SR_D_DESER_PARITY_EN.
- Defined: after WIDTH data bits the FSM enters PARITY; the next bit_en bit is an even-parity bit. parity_err <= ^{word, parity_bit}, registered together with out_data and valid only while out_valid=1; dropped words do not update it.
- Undefined: no PARITY state, words complete after WIDTH bits, parity_err tied 0.

## Structure
- Package sr_d_pkg: default WIDTH constant, FSM state enum (COLLECT, PARITY).
- One sub-module natural: sr_d_bit_counter (enable, synchronous active-low reset, terminal-count output at WIDTH-1). Shift register, output register and handshake stay in the top.

## Test plan
- WIDTH=8, reset low 2 cycles then high, bits 1,0,1,1,0,0,1,0 with bit_en=1, out_ready=1 -> out_data=0xB2, out_valid high one cycle, overflow=0.
- Same stream with bit_en low on alternating cycles -> identical 0xB2, appears 1 cycle after 8th qualified bit.
- out_ready=0, send 0xB2 then 0x5A -> out_data stays 0xB2, overflow=1; raise ovf_clr -> overflow=0; raise out_ready -> out_valid drops.
- Continuous stream 0x01,0x02,0x03 with out_ready=1 -> each word valid, no gaps lost, overflow=0.
- Reset asserted after 4 bits of 0xFF, then send 0x0F -> out_data=0x0F, no residue.
- With SR_D_DESER_PARITY_EN: send 0xB2 + parity 0 -> parity_err=0; 0xB2 + parity 1 -> parity_err=1.
